// File: rtl/mic_frame_sampler_if.sv
// Sample/frame handshake and read bus of the double-buffered mic sampler.
// slave: sampler side; master: producer + frame consumer side.
interface mic_frame_sampler_if #(
  parameter int N_MICS     = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int CH_WIDTH   = 2
) ();

  logic [N_MICS-1:0][DATA_WIDTH-1:0] mic_data_i;
  logic                              mic_valid_i;
  logic                              in_ready_o;

  logic                              frame_ready_o;
  logic                              frame_ready_pulse_o;
  logic                              frame_bank_o;
  logic                              frame_release_i;

  logic                              rd_en_i;
  logic [CH_WIDTH-1:0]               rd_ch_i;
  logic [ADDR_WIDTH-1:0]             rd_addr_i;
  logic [DATA_WIDTH-1:0]             rd_data_o;
  logic                              rd_valid_o;

  logic                              active_bank_o;
  logic [15:0]                       drop_cnt_o;
  logic [7:0]                        frame_seq_o;

  modport slave (
    input  mic_data_i,
    input  mic_valid_i,
    output in_ready_o,
    output frame_ready_o,
    output frame_ready_pulse_o,
    output frame_bank_o,
    input  frame_release_i,
    input  rd_en_i,
    input  rd_ch_i,
    input  rd_addr_i,
    output rd_data_o,
    output rd_valid_o,
    output active_bank_o,
    output drop_cnt_o,
    output frame_seq_o
  );

  modport master (
    output mic_data_i,
    output mic_valid_i,
    input  in_ready_o,
    input  frame_ready_o,
    input  frame_ready_pulse_o,
    input  frame_bank_o,
    output frame_release_i,
    output rd_en_i,
    output rd_ch_i,
    output rd_addr_i,
    input  rd_data_o,
    input  rd_valid_o,
    input  active_bank_o,
    input  drop_cnt_o,
    input  frame_seq_o
  );

endinterface

// File: rtl/mic_frame_sampler.sv
// Double-buffered (A/B) multi-mic frame capture with consumer handoff.
// Ports: clk_i, rst_ni (async low), bus (mic_frame_sampler_if.slave):
//   strobe in (mic_data_i/mic_valid_i/in_ready_o), frame handoff
//   (frame_ready_o/_pulse_o/frame_bank_o/frame_release_i), 1-cycle
//   read port (rd_*), status (active_bank_o, drop_cnt_o, frame_seq_o).
// Option: define MIC_FRAME_SAMPLER_SEQ_EN for the frame_seq_o counter.
module mic_frame_sampler #(
  parameter int N_MICS          = 4,
  parameter int DATA_WIDTH      = 16,
  parameter int SAMPLES_PER_BUF = 256,
  parameter int ADDR_WIDTH      = $clog2(SAMPLES_PER_BUF),
  parameter int CH_WIDTH        = $clog2(N_MICS > 1 ? N_MICS : 2)
) (
  input  logic clk_i,
  input  logic rst_ni,
  mic_frame_sampler_if.slave bus
);

  if (N_MICS < 1 || N_MICS > 16) begin : g_bad_mics
    $fatal(1, "mic_frame_sampler: N_MICS out of 1..16");
  end
  if (DATA_WIDTH < 8 || DATA_WIDTH > 32) begin : g_bad_dw
    $fatal(1, "mic_frame_sampler: DATA_WIDTH out of 8..32");
  end
  if (SAMPLES_PER_BUF < 2) begin : g_bad_spb
    $fatal(1, "mic_frame_sampler: SAMPLES_PER_BUF < 2");
  end
  if (ADDR_WIDTH < $clog2(SAMPLES_PER_BUF)) begin : g_bad_aw
    $fatal(1, "mic_frame_sampler: ADDR_WIDTH too small");
  end
  if (CH_WIDTH < $clog2(N_MICS > 1 ? N_MICS : 2)) begin : g_bad_cw
    $fatal(1, "mic_frame_sampler: CH_WIDTH too small");
  end

  typedef enum logic [1:0] {
    S_FILL      = 2'd0,
    S_FILL_PEND = 2'd1,
    S_STALL     = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX =
    ADDR_WIDTH'(SAMPLES_PER_BUF - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_idx_q, wr_idx_d;
  logic                    active_q, active_d;
  logic                    fbank_q, fbank_d;
  logic                    pulse_q, pulse_d;
  logic [15:0]             drop_q, drop_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;

  logic                    accept;
  logic                    last;
  logic                    rel;
  logic                    publish;
  logic [DATA_WIDTH-1:0]   rd_sel [N_MICS+1];

  assign accept = bus.mic_valid_i && (state_q != S_STALL);
  assign last   = accept && (wr_idx_q == LAST_IDX);
  assign rel    = bus.frame_release_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_FILL;
      wr_idx_q   <= '0;
      active_q   <= 1'b0;
      fbank_q    <= 1'b0;
      pulse_q    <= 1'b0;
      drop_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      active_q   <= active_d;
      fbank_q    <= fbank_d;
      pulse_q    <= pulse_d;
      drop_q     <= drop_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    drop_d   = drop_q;
    publish  = 1'b0;

    if (accept) begin
      wr_idx_d = last ? '0 : wr_idx_q + ADDR_WIDTH'(1);
    end

    unique case (state_q)
      S_FILL: begin
        if (last) begin
          publish = 1'b1;
          state_d = S_FILL_PEND;
        end
      end
      S_FILL_PEND: begin
        // A release landing with the last write frees the
        // published bank just in time: hand over, no stall.
        if (last && rel) begin
          publish = 1'b1;
        end else if (last) begin
          state_d = S_STALL;
        end else if (rel) begin
          state_d = S_FILL;
        end
      end
      S_STALL: begin
        if (bus.mic_valid_i && drop_q != 16'hFFFF) begin
          drop_d = drop_q + 16'd1;
        end
        // Waiting bank is still active_q: it was never toggled.
        if (rel) begin
          publish  = 1'b1;
          wr_idx_d = '0;
          state_d  = S_FILL_PEND;
        end
      end
      default: state_d = S_FILL;
    endcase

    active_d = publish ? ~active_q : active_q;
    fbank_d  = publish ? active_q : fbank_q;
    pulse_d  = publish;
  end

  always_comb begin
    bus.in_ready_o    = (state_q != S_STALL);
    bus.frame_ready_o = (state_q != S_FILL);
  end

  assign bus.frame_ready_pulse_o = pulse_q;
  assign bus.frame_bank_o        = fbank_q;
  assign bus.active_bank_o       = active_q;
  assign bus.drop_cnt_o          = drop_q;
  assign bus.rd_valid_o          = rd_valid_q;
  assign bus.rd_data_o           = rd_data_q;

  // Per-channel two-bank storage; read mux chains through the
  // channels so an out-of-range rd_ch_i falls through to zero.
  assign rd_sel[0] = '0;

  for (genvar c = 0; c < N_MICS; c++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem [2][SAMPLES_PER_BUF];

    always_ff @(posedge clk_i) begin
      if (accept) begin
        mem[active_q][wr_idx_q] <= bus.mic_data_i[c];
      end
    end

    assign rd_sel[c+1] = (bus.rd_ch_i == CH_WIDTH'(c))
                       ? mem[fbank_q][bus.rd_addr_i]
                       : rd_sel[c];
  end

  always_comb begin
    rd_valid_d = bus.rd_en_i;
    rd_data_d  = bus.rd_en_i ? rd_sel[N_MICS] : rd_data_q;
  end

`ifdef MIC_FRAME_SAMPLER_SEQ_EN
  logic [7:0] seq_q, seq_d;

  always_comb begin
    seq_d = publish ? seq_q + 8'd1 : seq_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) seq_q <= '0;
    else         seq_q <= seq_d;
  end

  assign bus.frame_seq_o = seq_q;
`else
  assign bus.frame_seq_o = '0;
`endif

endmodule
